// File: rtl/trisc_bus_pkg.sv
// Shared types and constants for the TRISC memory-bus arbiter.
//
// Contents:
//   arb_state_e       - arbiter FSM states (IDLE=0, GRANT=1, ACCESS=2, DONE=3)
//   DefAw / DefDw     - default address / data widths
//   REQ_FETCH/LS/IO   - requester slot indices
//   IdxW/WaitW/HoldW  - widths of the owner index, wait counter and hold counter
//   next_ptr()        - round-robin successor of a requester index
package trisc_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StAccess = 2'd2,
    StDone   = 2'd3
  } arb_state_e;

  localparam int unsigned DefAw = 8;
  localparam int unsigned DefDw = 16;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_LS    = 1;
  localparam int unsigned REQ_IO    = 2;

  // Owner index is exposed as a 2-bit port, so it supports up to four requesters.
  localparam int unsigned IdxW  = 2;
  localparam int unsigned WaitW = 3;
  localparam int unsigned HoldW = 4;

  // (idx + 1) mod nreq without a divider.
  function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] idx,
                                               input int unsigned     nreq);
    if (32'(idx) + 32'd1 >= nreq) begin
      return '0;
    end
    return idx + IdxW'(1);
  endfunction

endpackage

// File: rtl/trisc_rr_picker.sv
// Combinational round-robin winner selection for the TRISC bus arbiter.
//
// The search starts at ptr_i and moves upward modulo NReq; the first requester with its
// request bit set wins.
//
// Build option: define TRISC_ARB_FETCH_PRIORITY_EN to make requester 0 (instruction fetch)
// win every arbitration in which it requests, regardless of ptr_i.
//
// Ports:
//   req_i      - request vector
//   ptr_i      - round-robin start index
//   win_oh_o   - one-hot winner (all zero when nothing requests)
//   win_idx_o  - encoded winner index (0 when nothing requests)
//   any_req_o  - at least one request is pending
module trisc_rr_picker
  import trisc_bus_pkg::*;
#(
  parameter int unsigned NReq = 3
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NReq-1:0] win_oh_o,
  output logic [IdxW-1:0] win_idx_o,
  output logic            any_req_o
);

  localparam int unsigned SelW = (NReq > 1) ? $clog2(NReq) : 1;

  always_comb begin
    logic        found;
    int unsigned k;
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NReq; i++) begin
      k = (32'(ptr_i) + i) % NReq;
      if (!found && req_i[SelW'(k)]) begin
        found                = 1'b1;
        win_oh_o[SelW'(k)]   = 1'b1;
        win_idx_o            = IdxW'(k);
      end
    end
`ifdef TRISC_ARB_FETCH_PRIORITY_EN
    // Fetch overrides the rotation whenever it is asking.
    if (req_i[REQ_FETCH]) begin
      win_oh_o            = '0;
      win_oh_o[REQ_FETCH] = 1'b1;
      win_idx_o           = IdxW'(REQ_FETCH);
    end
`endif
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/trisc_bus_arbiter.sv
// Arbiter for the single-ported TRISC memory bus.
//
// Three requesters (0 = instruction fetch, 1 = load/store, 2 = I/O/DMA) share the memory
// through a req/grant/done handshake. A round-robin FSM (IDLE -> GRANT -> ACCESS -> DONE)
// registers the owner's address, write enable and write data, holds mem_en for
// WAIT_CYCLES+1 cycles, captures read data and pulses done for one cycle. An owner holding
// lock may chain further beats directly from DONE back to GRANT, limited to HOLD_MAX beats
// while anybody else is waiting.
//
// All state changes on the falling edge of CLK; CLR is an asynchronous active-low reset.
// Outputs decode only from registers, so there is no combinational path from req.
//
// Build option: TRISC_ARB_FETCH_PRIORITY_EN (see trisc_rr_picker) gives fetch absolute
// priority at every arbitration.
//
// Ports:
//   CLK, CLR              - clock (falling-edge active), async active-low reset
//   req, lock             - per-requester request level / burst hold
//   addr_i, we_i, wdata_i - packed per-requester address, write enable, write data
//   grant, done           - one-hot owner / one-cycle completion pulse
//   rdata                 - read data, held until the next completed read
//   mem_en, mem_we        - memory enable / write enable
//   mem_addr, mem_wdata   - registered address / write data
//   mem_rdata             - memory read data
//   busy, owner           - FSM not idle / encoded current or last owner
module trisc_bus_arbiter
  import trisc_bus_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned AW          = DefAw,
  parameter int unsigned DW          = DefDw,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned HOLD_MAX    = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ-1:0]   we_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  arb_state_e       state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             we_q, we_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  // Owner-indexed views of the request inputs.
  logic [NREQ-1:0]  owner_oh;
  logic [AW-1:0]    sel_addr;
  logic             sel_we;
  logic [DW-1:0]    sel_wdata;
  logic             sel_lock;
  logic             sel_req;
  logic             others_req;

  always_comb begin
    owner_oh   = '0;
    sel_addr   = '0;
    sel_we     = 1'b0;
    sel_wdata  = '0;
    sel_lock   = 1'b0;
    sel_req    = 1'b0;
    others_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_oh[i] = 1'b1;
        sel_addr    = addr_i[i*AW +: AW];
        sel_we      = we_i[i];
        sel_wdata   = wdata_i[i*DW +: DW];
        sel_lock    = lock[i];
        sel_req     = req[i];
      end else begin
        others_req = others_req | req[i];
      end
    end
  end

  // On leaving DONE the pointer moves past the owner before the new search, so the
  // picker sees the updated pointer in the same cycle.
  logic [IdxW-1:0] pick_ptr;
  logic [NREQ-1:0] win_oh;
  logic [IdxW-1:0] win_idx;
  logic            any_req;

  assign pick_ptr = (state_q == StDone) ? next_ptr(owner_q, NREQ) : rr_ptr_q;

  trisc_rr_picker #(
    .NReq(NREQ)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (pick_ptr),
    .win_oh_o (win_oh),
    .win_idx_o(win_idx),
    .any_req_o(any_req)
  );

  // Burst continues while the owner holds lock+req; once it has used HOLD_MAX beats it
  // must yield if someone else is waiting.
  logic hold_below;
  logic extend;

  assign hold_below = 32'(hold_cnt_q) < (HOLD_MAX - 32'd1);
  assign extend     = sel_lock & sel_req & (hold_below | ~others_req);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    hold_cnt_d = hold_cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = win_idx;
          state_d = StGrant;
        end
      end

      StGrant: begin
        addr_d     = sel_addr;
        we_d       = sel_we;
        wdata_d    = sel_wdata;
        wait_cnt_d = WaitW'(WAIT_CYCLES);
        state_d    = StAccess;
      end

      StAccess: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WaitW'(1);
        end else begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = StDone;
        end
      end

      StDone: begin
        if (extend) begin
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
          state_d = StGrant;
        end else begin
          rr_ptr_d   = pick_ptr;
          hold_cnt_d = '0;
          if (any_req) begin
            owner_d = win_idx;
            state_d = StGrant;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      wait_cnt_q <= '0;
      hold_cnt_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // win_oh is not needed here; grant is rebuilt from the registered owner instead.
  logic unused_win_oh;
  assign unused_win_oh = ^win_oh;

  assign busy      = (state_q != StIdle);
  assign grant     = busy ? owner_oh : '0;
  assign done      = (state_q == StDone) ? owner_oh : '0;
  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_trisc_bus_arbiter.sv
module tb_trisc_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int W  = 1;
  localparam int HM = 4;

  logic              CLK;
  logic              CLR;
  logic [N-1:0]      req;
  logic [N-1:0]      lock;
  logic [N*AW-1:0]   addr_i;
  logic [N-1:0]      we_i;
  logic [N*DW-1:0]   wdata_i;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic [DW-1:0]     rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              busy;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;

  trisc_bus_arbiter #(
    .NREQ(N), .AW(AW), .DW(DW), .WAIT_CYCLES(W), .HOLD_MAX(HM)
  ) dut (
    .CLK(CLK), .CLR(CLR), .req(req), .lock(lock), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .grant(grant), .done(done), .rdata(rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  // DUT state moves on negedge; inputs change and outputs are sampled 1 after posedge.
  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction phase counting) ----------------
  bit          m_busy;
  int          m_ph;     // 1 = grant cycle, 2..W+2 = memory cycles, W+3 = done cycle
  int          m_own;
  int          m_ptr;
  int          m_beats;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rd;

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef TRISC_ARB_FETCH_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ph = 0; m_own = 0; m_ptr = 0; m_beats = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_rd = '0;
  endtask

  task automatic model_advance();
    logic [N-1:0] others;
    if (!m_busy) begin
      if (req != '0) begin
        m_own = pick(req, m_ptr); m_busy = 1; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      m_addr  = addr_i[m_own*AW +: AW];
      m_we    = we_i[m_own];
      m_wdata = wdata_i[m_own*DW +: DW];
      m_ph    = 2;
    end else if (m_ph < W + 2) begin
      m_ph++;
    end else if (m_ph == W + 2) begin
      if (!m_we) m_rd = mem_rdata;
      m_ph = W + 3;
    end else begin
      others = req & ~(3'b001 << m_own);
      if (lock[m_own] && req[m_own] && (m_beats < HM - 1 || others == '0)) begin
        if (m_beats < 15) m_beats++;
        m_ph = 1;
      end else begin
        m_ptr   = (m_own + 1) % N;
        m_beats = 0;
        if (req != '0) begin
          m_own = pick(req, m_ptr); m_ph = 1;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic compare_model(input int cyc);
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic         en;
    g  = m_busy ? (3'b001 << m_own) : 3'b000;
    d  = (m_busy && m_ph == W + 3) ? (3'b001 << m_own) : 3'b000;
    en = m_busy && m_ph >= 2 && m_ph <= W + 2;
    check($sformatf("rand%0d_grant", cyc), 32'(grant), 32'(g));
    check($sformatf("rand%0d_done", cyc), 32'(done), 32'(d));
    check($sformatf("rand%0d_mem_en", cyc), 32'(mem_en), 32'(en));
    check($sformatf("rand%0d_mem_we", cyc), 32'(mem_we), 32'(en & m_we));
    check($sformatf("rand%0d_mem_addr", cyc), 32'(mem_addr), 32'(m_addr));
    check($sformatf("rand%0d_mem_wdata", cyc), 32'(mem_wdata), 32'(m_wdata));
    check($sformatf("rand%0d_rdata", cyc), 32'(rdata), 32'(m_rd));
    check($sformatf("rand%0d_busy", cyc), 32'(busy), 32'(m_busy));
    check($sformatf("rand%0d_owner", cyc), 32'(owner), 32'(m_own));
  endtask

  task automatic do_reset();
    CLR = 1'b0; req = '0; lock = '0; we_i = '0; addr_i = '0; wdata_i = '0; mem_rdata = '0;
    step();
    step();
    CLR = 1'b1;
    model_reset();
  endtask

  // ---------------- directed single-read vectors ----------------
  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          en;
    logic [N-1:0]  done;
    logic          busy;
    logic [1:0]    owner;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [N-1:0] exp_g;
    int           cnt;
    bit           got;

    vecs[0] = '{req: 3'b010, grant: 3'b010, en: 1'b0, done: 3'b000, busy: 1'b1, owner: 2'd1,
                addr: 8'h00, rdata: 16'h0000};
    vecs[1] = '{req: 3'b000, grant: 3'b010, en: 1'b1, done: 3'b000, busy: 1'b1, owner: 2'd1,
                addr: 8'h2A, rdata: 16'h0000};
    vecs[2] = '{req: 3'b000, grant: 3'b010, en: 1'b1, done: 3'b000, busy: 1'b1, owner: 2'd1,
                addr: 8'h2A, rdata: 16'h0000};
    vecs[3] = '{req: 3'b000, grant: 3'b010, en: 1'b0, done: 3'b010, busy: 1'b1, owner: 2'd1,
                addr: 8'h2A, rdata: 16'hBEEF};
    vecs[4] = '{req: 3'b000, grant: 3'b000, en: 1'b0, done: 3'b000, busy: 1'b0, owner: 2'd1,
                addr: 8'h2A, rdata: 16'hBEEF};

    // Reset held with all requests pending.
    CLR = 1'b0; req = 3'b111; lock = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_grant", 32'(grant), 32'd0);
      check("reset_mem_en", 32'(mem_en), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_owner", 32'(owner), 32'd0);
      check("reset_done", 32'(done), 32'd0);
    end
    CLR = 1'b1;
    step();
    check("post_reset_grant", 32'(grant), 32'b001);
    check("post_reset_busy", 32'(busy), 32'd1);

    // Single read from load/store; req drops after the grant.
    do_reset();
    addr_i    = 24'h002A00;
    mem_rdata = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      req = vecs[i].req;
      step();
      check($sformatf("rd%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      check($sformatf("rd%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      check($sformatf("rd%0d_mem_we", i), 32'(mem_we), 32'd0);
      check($sformatf("rd%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("rd%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("rd%0d_owner", i), 32'(owner), 32'(vecs[i].owner));
      check($sformatf("rd%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      check($sformatf("rd%0d_rdata", i), 32'(rdata), 32'(vecs[i].rdata));
    end

    // Rotation with every requester pending, no lock.
    do_reset();
    req = 3'b111;
    step();
    for (int k = 0; k < 6; k++) begin
`ifdef TRISC_ARB_FETCH_PRIORITY_EN
      exp_g = 3'b001;
`else
      exp_g = 3'b001 << (k % 3);
`endif
      check($sformatf("rr%0d_grant", k), 32'(grant), 32'(exp_g));
      for (int c = 1; c <= W + 2; c++) begin
        step();
        check($sformatf("rr%0d_hold%0d", k, c), 32'(grant), 32'(exp_g));
      end
      check($sformatf("rr%0d_done", k), 32'(done), 32'(exp_g));
      step();
    end

    // Locked burst by I/O is cut after HOLD_MAX beats when fetch waits.
    do_reset();
    req  = 3'b100;
    lock = 3'b100;
    step();
    check("lock_first_grant", 32'(grant), 32'b100);
    req = 3'b101;
    cnt = 0;
    got = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      if (done == 3'b100) cnt++;
      if (grant == 3'b001) got = 1;
      else step();
    end
    check("lock_done_count", 32'(cnt), 32'(HM));
    check("lock_handover", 32'(got), 32'd1);

    // Write from fetch, aborted by reset during the memory access.
    do_reset();
    req     = 3'b001;
    we_i    = 3'b001;
    wdata_i = 48'h0000_0000_1234;
    addr_i  = 24'h000055;
    step();
    req = '0;
    step();
    check("wr_mem_en", 32'(mem_en), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    check("wr_mem_addr", 32'(mem_addr), 32'h55);
    CLR = 1'b0;
    #1;
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    step();
    CLR = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("abort_no_done%0d", c), 32'(done), 32'd0);
      check($sformatf("abort_idle%0d", c), 32'(busy), 32'd0);
    end

    // Randomised traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      compare_model(c);
      req       = 3'($urandom_range(0, 7));
      lock      = 3'($urandom_range(0, 7));
      we_i      = 3'($urandom_range(0, 7));
      addr_i    = 24'($urandom);
      wdata_i   = {16'($urandom), 32'($urandom)};
      mem_rdata = 16'($urandom);
      model_advance();
      step();
    end
    compare_model(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
